wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 8-bit pipelined core.
- Sits directly downstream of the MEM/WB pipeline latch and consumes its outputs: ALU result, memory read data and the MemToReg select.
- Selects the writeback value, commits it to an 8 x 8-bit register bank and serves two combinational read ports to decode.
- Keeps a saturating retired-write counter and a registered writeback status for debug and hazard logic.

Parameters:
- DATA_W, 8, datapath width in bits.
- NREGS, 8, number of architectural registers. Address width is log2(NREGS).
- CNT_W, 16, width of retire_count.

Ports:
- clk1  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_in  input  DATA_W  ALU result from the MEM/WB latch.
- mem_in  input  DATA_W  memory read data from the MEM/WB latch.
- MemToRegmux  input  1  writeback select: 1 = mem_in, 0 = alu_in.
- RegWrite  input  1  commit the writeback value this cycle.
- wr_addr  input  3  destination register.
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- wb_data  output  DATA_W  selected writeback value (combinational).
- wb_valid  output  1  registered; high the cycle after a committed write.
- wb_last_addr  output  3  registered; destination of the last committed write.
- retire_count  output  CNT_W  registered count of RegWrite cycles.

Behaviour:
- Clocking and reset: one clock, clk1; reset rst is synchronous, active-high.
- wb_data = MemToRegmux ? mem_in : alu_in. Purely combinational, no latency.
- R0 is hardwired to zero.
  - A write to address 0 is discarded.
  - A read of address 0 always returns 0.
- On rising clk1 with rst=1:
  - all registers R1..R7 are set to 0;
  - wb_valid=0, wb_last_addr=0, retire_count=0.
  - rst has priority over any simultaneous RegWrite. A write presented in the reset cycle is lost.
- On rising clk1 with rst=0 and RegWrite=1:
  - if wr_addr!=0, regs[wr_addr] <= wb_data;
  - wb_valid <= (wr_addr!=0);
  - wb_last_addr <= wr_addr only when wr_addr!=0, otherwise it holds its value;
  - retire_count increments by 1 (address-0 writes are counted too) and saturates at all-ones, never wrapping.
- On rising clk1 with rst=0 and RegWrite=0: wb_valid <= 0. All other state holds.
- Write latency: the value is visible on a read port the cycle after the commit edge (unless the optional bypass is enabled).
- Reads are asynchronous. Both ports may address the same register, and both return the same value.
- X on MemToRegmux while RegWrite=0 has no effect on state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-through bypass.
  - If RegWrite=1, wr_addr!=0 and rd_addr_x==wr_addr, rd_data_x returns wb_data in the same cycle. This applies independently per port.
  - Address 0 is never bypassed.
- Not defined: read ports always return stored register contents. A same-cycle read of the register being written returns the old value.

Test Plan:
- Reset: assert rst for 2 cycles with RegWrite=1, wr_addr=3, alu_in=8'hAA.
  -> all reads return 0, wb_valid=0, retire_count=0, R3=0 after release.
- Mux select: alu_in=8'h12, mem_in=8'h34, RegWrite=1, wr_addr=2.
  - MemToRegmux=0 -> next cycle R2=8'h12.
  - Repeat with MemToRegmux=1 -> R2=8'h34, wb_valid=1, wb_last_addr=2.
- R0 protection: write 8'hFF to address 0.
  -> rd_data_a with rd_addr_a=0 returns 0; wb_valid=0; retire_count increments by 1; wb_last_addr unchanged.
- Same-cycle read/write: R5=8'h01, then write 8'h77 to R5 with rd_addr_a=rd_addr_b=5 in the same cycle.
  - With WB_BYPASS_EN: both ports return 8'h77.
  - Without: both return 8'h01, and 8'h77 appears the next cycle.
- Counter saturation: set CNT_W=4 and hold RegWrite=1 for 20 cycles.
  -> retire_count reaches 4'hF and stays there.
  - Then assert rst -> retire_count=0.
- Reset mid-stream: alternate writes to R1..R7 each cycle and assert rst for one cycle mid-sequence.
  -> all registers read 0 the cycle after reset.
  - Writes resume correctly on the following edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback mux, 8-entry register file (R0 hardwired to zero), saturating retire counter and registered status.
// Reads are combinational, writes land on the clock edge. Define WB_BYPASS_EN to forward the same-cycle write to the read ports.
module wb_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic              MemToRegmux,
    input  logic              RegWrite,
    input  logic [AW-1:0]     wr_addr,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_last_addr,
    output logic [CNT_W-1:0]  retire_count
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_wb_valid;
    logic [AW-1:0]     r_last_addr;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    assign wb_data = MemToRegmux ? mem_in : alu_in;

    // Address-0 writes still retire (counted) but never touch the bank or the status.
    assign w_wr_en = RegWrite && (wr_addr != '0);

    assign w_stored_a = (rd_addr_a == '0) ? '0 : r_regs[rd_addr_a];
    assign w_stored_b = (rd_addr_b == '0) ? '0 : r_regs[rd_addr_b];

`ifdef WB_BYPASS_EN
    assign rd_data_a = (w_wr_en && (rd_addr_a == wr_addr)) ? wb_data : w_stored_a;
    assign rd_data_b = (w_wr_en && (rd_addr_b == wr_addr)) ? wb_data : w_stored_b;
`else
    assign rd_data_a = w_stored_a;
    assign rd_data_b = w_stored_b;
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_valid   <= 1'b0;
            r_last_addr  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_wb_valid <= w_wr_en;
            if (w_wr_en) begin
                r_regs[wr_addr] <= wb_data;
                r_last_addr     <= wr_addr;
            end
            if (RegWrite && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_last_addr = r_last_addr;
    assign retire_count = r_retire_cnt;

endmodule
